// File: rtl/menu_key_scheduler.sv
// ---------------------------------------------------------------------------
// menu_key_scheduler
//
// Draws four 32x32 on-screen key icons from one shared key bitmap. It
// debounces the physical keys and flashes the icon of the key that was
// accepted.
//
// Pixel path (2-cycle latency from pixelX/pixelY to RGBout/drawingRequest):
//   comb    : find which icon (if any) the scan pixel falls in and drive
//             insideRectangle/offsetX/offsetY to the shared bitmap
//   stage 1 : register hit flag and icon index so they line up with
//             bitmapRGB/bitmapDR, which return one cycle later
//   stage 2 : register drawingRequest and RGBout, recolouring the selected
//             icon during the "on" half of each flash period
//
// Key path: IDLE -> DEBOUNCE -> FLASH -> WAIT_RELEASE -> IDLE, with a frame
// counter that only advances on startOfFrame and saturates.
//
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   pixelX, pixelY       : current scan pixel
//   startOfFrame         : one-cycle pulse per frame
//   keyPress[3:0]        : key levels
//   bitmapRGB, bitmapDR  : shared bitmap colour / draw request (1-cycle lat.)
//   offsetX, offsetY,
//   insideRectangle      : combinational address/enable to the shared bitmap
//   drawingRequest,
//   RGBout               : registered pixel output
//   selectedKey          : key currently being debounced/flashed
//   keyEvent             : one-cycle pulse on FLASH entry
//   dbg_state            : FSM state (0 IDLE, 1 DEBOUNCE, 2 FLASH, 3 WAIT_RELEASE)
//   dbg_count            : frame counter, zero-extended
//   dbg_flash_phase      : 1 while the selected icon is being recoloured
// ---------------------------------------------------------------------------
module menu_key_scheduler #(
  parameter logic [10:0] BASE_X          = 11'd192,
  parameter logic [10:0] BASE_Y          = 11'd400,
  parameter logic [10:0] PITCH_X         = 11'd64,
  parameter int          DEBOUNCE_FRAMES = 3,
  parameter int          FLASH_FRAMES    = 8,
  parameter logic [7:0]  HIGHLIGHT_RGB   = 8'hFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic [3:0]  keyPress,
  input  logic [7:0]  bitmapRGB,
  input  logic        bitmapDR,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        insideRectangle,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic [1:0]  selectedKey,
  output logic        keyEvent,
  output logic [1:0]  dbg_state,
  output logic [7:0]  dbg_count,
  output logic        dbg_flash_phase
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_DEBOUNCE     = 2'd1,
    ST_FLASH        = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

  localparam int CNT_MAX = (DEBOUNCE_FRAMES > FLASH_FRAMES) ? DEBOUNCE_FRAMES : FLASH_FRAMES;
  // At least two bits so the flash phase (bit 1) always exists.
  localparam int CNT_W = (CNT_MAX < 4) ? 2 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] DEB_CNT   = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] FLASH_CNT = CNT_W'(FLASH_FRAMES);

  // ---------------- icon hit detection (combinational) ----------------
  // 14-bit arithmetic so BASE_X + 3*PITCH_X + 32 can never wrap.
  logic [13:0] px_w, py_w, top_w, left_w;
  logic        hit_d;
  logic [1:0]  hit_idx_d;
  logic [10:0] off_x, off_y;

  assign px_w  = {3'b000, pixelX};
  assign py_w  = {3'b000, pixelY};
  assign top_w = {3'b000, BASE_Y};

  always_comb begin
    hit_d     = 1'b0;
    hit_idx_d = 2'd0;
    off_x     = 11'd0;
    off_y     = 11'd0;
    left_w    = 14'd0;
    for (int k = 0; k < 4; k++) begin
      left_w = {3'b000, BASE_X} + 14'(k) * {3'b000, PITCH_X};
      if (!hit_d && py_w >= top_w && py_w < top_w + 14'd32 &&
          px_w >= left_w && px_w < left_w + 14'd32) begin
        hit_d     = 1'b1;
        hit_idx_d = 2'(k);
        off_x     = 11'(px_w - left_w);
        off_y     = 11'(py_w - top_w);
      end
    end
  end

  assign insideRectangle = hit_d;
  assign offsetX         = off_x;
  assign offsetY         = off_y;

  // ---------------- key FSM ----------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_adv;
  logic [1:0]       sel_q, sel_d;
  logic             key_event_q, key_event_d;
  logic [1:0]       lowest_key;

  always_comb begin
    lowest_key = 2'd3;
    if (keyPress[0])      lowest_key = 2'd0;
    else if (keyPress[1]) lowest_key = 2'd1;
    else if (keyPress[2]) lowest_key = 2'd2;
  end

  assign cnt_adv = (startOfFrame && cnt_q != CNT_SAT) ? cnt_q + 1'b1 : cnt_q;

  // Exit conditions are checked before counting, so a frame pulse that
  // coincides with a transition is dropped and the counter clears.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    key_event_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (keyPress != 4'd0) begin
          sel_d   = lowest_key;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (!keyPress[sel_q]) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DEB_CNT) begin
          state_d     = ST_FLASH;
          cnt_d       = '0;
          key_event_d = 1'b1;
        end else begin
          cnt_d = cnt_adv;
        end
      end
      ST_FLASH: begin
        // Key level is deliberately ignored: releasing does not cut the flash short.
        if (cnt_q >= FLASH_CNT) begin
          state_d = ST_WAIT_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_adv;
        end
      end
      ST_WAIT_RELEASE: begin
        cnt_d = '0;
        if (keyPress == 4'd0) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= 2'd0;
      key_event_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      key_event_q <= key_event_d;
    end
  end

  logic flash_on;
  assign flash_on = (state_q == ST_FLASH) && cnt_q[1];

  // ---------------- pixel pipeline ----------------
  logic       hit_q;
  logic [1:0] hit_idx_q;
  logic       dr_q, dr_d;
  logic [7:0] rgb_q, rgb_d;

  always_comb begin
    dr_d  = bitmapDR & hit_q;
    rgb_d = 8'h00;
    if (dr_d) begin
      // Pure black/white pixels (outline, background) are never recoloured.
      if (hit_idx_q == sel_q && flash_on && bitmapRGB != 8'h00 && bitmapRGB != 8'hFF)
        rgb_d = HIGHLIGHT_RGB;
      else
        rgb_d = bitmapRGB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q     <= 1'b0;
      hit_idx_q <= 2'd0;
      dr_q      <= 1'b0;
      rgb_q     <= 8'h00;
    end else begin
      hit_q     <= hit_d;
      hit_idx_q <= hit_idx_d;
      dr_q      <= dr_d;
      rgb_q     <= rgb_d;
    end
  end

  assign drawingRequest  = dr_q;
  assign RGBout          = rgb_q;
  assign selectedKey     = sel_q;
  assign keyEvent        = key_event_q;
  assign dbg_state       = state_q;
  assign dbg_count       = 8'(cnt_q);
  assign dbg_flash_phase = flash_on;

endmodule

// File: tb/tb_menu_key_scheduler.sv
// ---------------------------------------------------------------------------
// tb_menu_key_scheduler
//
// Inputs change 2 time units after each rising edge. The reference model
// updates on the rising edge from those stable inputs, and all outputs are
// compared on the falling edge. Frame pulses come from a separate generator
// (periodic for directed scenarios, random afterwards).
// ---------------------------------------------------------------------------
module tb_menu_key_scheduler;

  localparam int BX = 192, BY = 400, PX = 64;
  localparam int DEB = 3, FL = 8, CMAX = 8;
  localparam logic [7:0] HL = 8'hFC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame;
  logic [3:0]  keyPress;
  logic [7:0]  bitmapRGB;
  logic        bitmapDR;
  logic [10:0] offsetX, offsetY;
  logic        insideRectangle, drawingRequest, keyEvent, dbg_flash_phase;
  logic [7:0]  RGBout, dbg_count;
  logic [1:0]  selectedKey, dbg_state;

  menu_key_scheduler dut (
    .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .keyPress(keyPress), .bitmapRGB(bitmapRGB),
    .bitmapDR(bitmapDR), .offsetX(offsetX), .offsetY(offsetY),
    .insideRectangle(insideRectangle), .drawingRequest(drawingRequest),
    .RGBout(RGBout), .selectedKey(selectedKey), .keyEvent(keyEvent),
    .dbg_state(dbg_state), .dbg_count(dbg_count), .dbg_flash_phase(dbg_flash_phase)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame pulse generator ----------------
  int sof_mode = 0;  // 0 off, 1 every 4th cycle, 2 random
  int sof_ctr  = 0;
  initial begin
    startOfFrame = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sof_ctr++;
      case (sof_mode)
        1:       startOfFrame = (sof_ctr % 4 == 0);
        2:       startOfFrame = ($urandom_range(0, 3) == 0);
        default: startOfFrame = 1'b0;
      endcase
    end
  end

  // ---------------- reference model ----------------
  // Icon geometry straight from the placement rule.
  function automatic void pixel_map(input int x, input int y, output bit in,
                                    output int idx, output int ox, output int oy);
    in = 0; idx = 0; ox = 0; oy = 0;
    for (int k = 0; k < 4; k++) begin
      int lx = BX + k * PX;
      if (x >= lx && x < lx + 32 && y >= BY && y < BY + 32) begin
        in = 1; idx = k; ox = x - lx; oy = y - BY;
      end
    end
  endfunction

  function automatic int lowest_set(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  localparam int M_IDLE = 0, M_DEB = 1, M_FLASH = 2, M_WAIT = 3;
  int         m_mode, m_frames, m_sel, m_s1_idx;
  bit         m_ev, m_s1_in;
  logic [8:0] exp_q[$];  // {drawingRequest, RGBout} in output order

  always @(posedge clk) begin
    if (reset) begin
      m_mode = M_IDLE; m_frames = 0; m_sel = 0; m_ev = 0;
      m_s1_in = 0; m_s1_idx = 0;
      exp_q.delete();
    end else begin
      bit dr, recolor, in;
      int idx, ox, oy;
      logic [7:0] rgb;
      // output stage uses the pixel seen one cycle ago and today's bitmap data
      dr = bitmapDR && m_s1_in;
      recolor = (m_s1_idx == m_sel) && (m_mode == M_FLASH) && ((m_frames / 2) % 2 == 1) &&
                (bitmapRGB != 8'h00) && (bitmapRGB != 8'hFF);
      rgb = !dr ? 8'h00 : (recolor ? HL : bitmapRGB);
      exp_q.push_back({dr, rgb});
      pixel_map(pixelX, pixelY, in, idx, ox, oy);
      m_s1_in = in; m_s1_idx = idx;
      // key sequencing
      m_ev = 0;
      case (m_mode)
        M_IDLE: if (keyPress != 0) begin
          m_sel = lowest_set(keyPress); m_mode = M_DEB; m_frames = 0;
        end
        M_DEB: begin
          if (!keyPress[m_sel]) begin m_mode = M_IDLE; m_frames = 0; end
          else if (m_frames >= DEB) begin m_mode = M_FLASH; m_frames = 0; m_ev = 1; end
          else if (startOfFrame) m_frames = (m_frames + 1 > CMAX) ? CMAX : m_frames + 1;
        end
        M_FLASH: begin
          if (m_frames >= FL) begin m_mode = M_WAIT; m_frames = 0; end
          else if (startOfFrame) m_frames = (m_frames + 1 > CMAX) ? CMAX : m_frames + 1;
        end
        default: begin
          m_frames = 0;
          if (keyPress == 0) m_mode = M_IDLE;
        end
      endcase
    end
  end

  // ---------------- scoreboard / compare ----------------
  int ev_seen = 0, flash_sofs = 0, deb_sofs = 0;

  always @(negedge clk) begin
    bit in;
    int idx, ox, oy;
    logic [8:0] e;
    pixel_map(pixelX, pixelY, in, idx, ox, oy);
    chk("inside", insideRectangle, in);
    chk("offsetX", offsetX, ox);
    chk("offsetY", offsetY, oy);
    if (reset) begin
      chk("rst_dr", drawingRequest, 0);
      chk("rst_rgb", RGBout, 0);
      chk("rst_sel", selectedKey, 0);
      chk("rst_event", keyEvent, 0);
      chk("rst_state", dbg_state, 0);
      chk("rst_count", dbg_count, 0);
    end else begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'd0;
      chk("drawingRequest", drawingRequest, e[8]);
      chk("RGBout", RGBout, e[7:0]);
      chk("selectedKey", selectedKey, m_sel);
      chk("keyEvent", keyEvent, m_ev);
      chk("state", dbg_state, m_mode);
      chk("count", dbg_count, m_frames);
      chk("flash_phase", dbg_flash_phase, (m_mode == M_FLASH) && ((m_frames / 2) % 2 == 1));
      if (keyEvent) ev_seen++;
      if (dbg_state == 2'd2 && startOfFrame) flash_sofs++;
      if (dbg_state == 2'd1 && startOfFrame) deb_sofs++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input int st, input int maxc, input string nm);
    for (int i = 0; i < maxc; i++) begin
      if (dbg_state == st) break;
      step();
    end
    chk(nm, dbg_state, st);
  endtask

  // Pixel on cycle N, bitmap data on N+1, expected output after the N+2 edge.
  task automatic rgb_case(input int x, input logic [7:0] c, input int exp, input string nm);
    pixelX = 11'(x); pixelY = 11'd410; bitmapDR = 1'b0;
    step();
    bitmapRGB = c; bitmapDR = 1'b1; pixelX = 11'd0; pixelY = 11'd0;
    step();
    bitmapDR = 1'b0;
    @(negedge clk);
    chk(nm, RGBout, exp);
  endtask

  // ---------------- stimulus ----------------
  int ev_base;

  initial begin
    reset = 1'b1; pixelX = 0; pixelY = 0; keyPress = 0; bitmapRGB = 0; bitmapDR = 0;
    repeat (3) step();
    @(negedge clk);
    chk("lit_reset_rgb", RGBout, 0);
    chk("lit_reset_state", dbg_state, 0);
    step();
    reset = 1'b0;

    // icon geometry
    pixelX = 11'd256; pixelY = 11'd410;
    @(negedge clk);
    chk("lit_geo_offx", offsetX, 0);
    chk("lit_geo_offy", offsetY, 10);
    chk("lit_geo_inside", insideRectangle, 1);
    step();
    pixelX = 11'd290;
    @(negedge clk);
    chk("lit_gap_inside", insideRectangle, 0);
    chk("lit_gap_offx", offsetX, 0);
    step();

    // full press sequence, two keys down
    sof_mode = 1;
    ev_base = ev_seen; flash_sofs = 0;
    keyPress = 4'b0110;
    wait_state(3, 300, "seq_reach_wait");
    @(negedge clk);
    chk("lit_seq_sel", selectedKey, 1);
    chk("lit_seq_events", ev_seen - ev_base, 1);
    chk("lit_seq_flash_frames", flash_sofs, 8);
    repeat (6) step();
    chk("lit_seq_hold_wait", dbg_state, 3);
    keyPress = 4'b0000;
    step();
    chk("lit_seq_idle", dbg_state, 0);

    // early release during debounce
    ev_base = ev_seen; deb_sofs = 0;
    keyPress = 4'b0100;
    for (int i = 0; i < 100 && deb_sofs < 2; i++) step();
    keyPress = 4'b0000;
    repeat (2) step();
    chk("lit_early_idle", dbg_state, 0);
    chk("lit_early_no_event", ev_seen - ev_base, 0);
    chk("lit_early_sel", selectedKey, 2);

    // recolour during flash
    keyPress = 4'b0001;
    wait_state(2, 200, "rc_reach_flash");
    for (int i = 0; i < 40 && !dbg_flash_phase; i++) step();
    rgb_case(200, 8'h71, 8'hFC, "lit_rc_highlight");
    rgb_case(200, 8'hFF, 8'hFF, "lit_rc_white");
    rgb_case(264, 8'h71, 8'h71, "lit_rc_other_key");
    wait_state(3, 200, "rc_reach_wait");
    keyPress = 4'b0000;
    repeat (2) step();

    // reset in the middle of the flash
    keyPress = 4'b0001;
    wait_state(2, 200, "rst_reach_flash");
    flash_sofs = 0;
    for (int i = 0; i < 100 && flash_sofs < 4; i++) step();
    reset = 1'b1; pixelX = 0; pixelY = 0;
    @(negedge clk);
    chk("lit_rstf_state", dbg_state, 0);
    chk("lit_rstf_rgb", RGBout, 0);
    chk("lit_rstf_event", keyEvent, 0);
    step();
    reset = 1'b0;
    deb_sofs = 0; ev_base = ev_seen;
    for (int i = 0; i < 200 && !keyEvent; i++) step();
    chk("lit_rstf_restart_event", keyEvent, 1);
    chk("lit_rstf_restart_frames", deb_sofs, 3);
    wait_state(3, 200, "rstf_reach_wait");
    keyPress = 4'b0000;
    repeat (2) step();

    // release on the same cycle as a frame pulse
    ev_base = ev_seen;
    keyPress = 4'b1000;
    step();
    for (int i = 0; i < 20 && !(startOfFrame && dbg_state == 2'd1); i++) step();
    keyPress = 4'b0000;
    @(negedge clk);
    step();
    chk("lit_coinc_idle", dbg_state, 0);
    chk("lit_coinc_count", dbg_count, 0);
    chk("lit_coinc_no_event", ev_seen - ev_base, 0);

    // random traffic
    sof_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) reset = 1'b1;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 2))
          0:       keyPress = 4'b0000;
          1:       keyPress = 4'(1 << $urandom_range(0, 3));
          default: keyPress = 4'($urandom_range(0, 15));
        endcase
      end
      pixelX = 11'($urandom_range(180, 420));
      pixelY = 11'($urandom_range(390, 440));
      case ($urandom_range(0, 3))
        0:       bitmapRGB = 8'h00;
        1:       bitmapRGB = 8'hFF;
        default: bitmapRGB = 8'($urandom_range(0, 255));
      endcase
      bitmapDR = 1'($urandom_range(0, 1));
    end
    step();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/menu_key_scheduler.md
MENU_KEY_SCHEDULER -- requirements
Module: menu_key_scheduler

Interface
REQ-001 SHALL have parameter BASE_X, default 11'd192: left edge of key 0 icon.
REQ-002 SHALL have parameter BASE_Y, default 11'd400: top edge of all key icons.
REQ-003 SHALL have parameter PITCH_X, default 11'd64: horizontal distance between icon left edges; SHALL be at least 32.
REQ-004 SHALL have parameter DEBOUNCE_FRAMES, default 3: frames a press must stay stable.
REQ-005 SHALL have parameter FLASH_FRAMES, default 8: length of the flash state, in frames.
REQ-006 SHALL have parameter HIGHLIGHT_RGB, default 8'hFC: recolor value used while flashing.
REQ-007 SHALL have ports: clk in 1, system clock; reset in 1, asynchronous active-high reset.
REQ-008 SHALL have ports: pixelX in 11, pixelY in 11, current scan pixel; startOfFrame in 1, one-cycle pulse per frame.
REQ-009 SHALL have ports: keyPress in 4, level per key; bitmapRGB in 8, from the shared 32x32 key bitmap (1-cycle latency); bitmapDR in 1, drawing request from that bitmap.
REQ-010 SHALL have ports: offsetX out 11, offsetY out 11, insideRectangle out 1, all driving the shared bitmap.
REQ-011 SHALL have ports: drawingRequest out 1; RGBout out 8; selectedKey out 2; keyEvent out 1.

Function
REQ-012 SHALL place four 32x32 icons; key k covers x in [BASE_X+k*PITCH_X, +32) and y in [BASE_Y, +32).
REQ-013 SHALL drive insideRectangle, offsetX and offsetY combinationally.
REQ-014 While the pixel is inside icon k: insideRectangle=1 and offset = pixel - icon top-left. Otherwise all three outputs SHALL be 0.
REQ-015 SHALL register the hit index and hit flag (stage 1) so they align with bitmapRGB, which arrives 1 cycle later.
REQ-016 SHALL register RGBout and drawingRequest at stage 2, giving 2 cycles total latency from pixelX/pixelY to output.
REQ-017 Stage-2 output: drawingRequest = bitmapDR AND stage-1 hit.
REQ-018 Stage-2 recolor: if stage-1 index == selectedKey, FSM is in FLASH, flashPhase=1 and bitmapRGB is neither 8'h00 nor 8'hFF, RGBout = HIGHLIGHT_RGB; otherwise RGBout = bitmapRGB. When not drawing, RGBout = 8'h00.
REQ-019 SHALL run one FSM with states IDLE, DEBOUNCE, FLASH, WAIT_RELEASE, plus a frame counter that advances only on startOfFrame.
REQ-020 IDLE: if keyPress != 0, latch the lowest set index into selectedKey, clear the counter and go to DEBOUNCE.
REQ-021 DEBOUNCE: if keyPress[selectedKey] drops, go to IDLE. Otherwise, when the counter reaches DEBOUNCE_FRAMES, go to FLASH. Other keys SHALL be ignored.
REQ-022 On the FLASH entry cycle, keyEvent SHALL pulse high for exactly one cycle.
REQ-023 FLASH: flashPhase = counter bit 1 (toggles every 2 frames, starting at 0). After FLASH_FRAMES frames, go to WAIT_RELEASE. Releasing the key SHALL NOT shorten FLASH.
REQ-024 WAIT_RELEASE: stay until keyPress == 0 for one full cycle, then go to IDLE. No new press is accepted until then.
REQ-025 selectedKey SHALL hold its value in every state except IDLE.
REQ-026 If startOfFrame and a state exit condition occur in the same cycle, the transition takes priority and the counter SHALL clear.
REQ-027 Counter SHALL saturate at max(DEBOUNCE_FRAMES, FLASH_FRAMES) and never wrap.

Reset
REQ-028 While reset is high, all of the following SHALL be forced asynchronously: state=IDLE, counter=0, selectedKey=0, keyEvent=0, RGBout=8'h00, drawingRequest=0, stage-1 registers=0.
REQ-029 Reset mid-FLASH SHALL abort the sequence with no keyEvent pulse. After release, a held key SHALL restart from DEBOUNCE.

Verification
REQ-030 Pixel (256,410) with defaults -> same cycle: offsetX=0, offsetY=10, insideRectangle=1; stage-1 index=1. Pixel (290,410) -> insideRectangle=0, offsets 0.
REQ-031 keyPress=4'b0110 held for 3 frames -> selectedKey=1; one keyEvent pulse; FLASH lasts exactly 8 startOfFrame pulses; then WAIT_RELEASE until keyPress=0.
REQ-032 keyPress[2] released after 2 frames in DEBOUNCE -> return to IDLE, no keyEvent.
REQ-033 In FLASH with flashPhase=1 and selectedKey=0, bitmapRGB=8'h71 on a key-0 pixel -> RGBout=8'hFC two cycles after the pixel. Same case with 8'hFF -> RGBout=8'hFF. Same case on a key-1 pixel -> RGBout=8'h71.
REQ-034 reset asserted during FLASH frame 4 -> next cycle all outputs are 0 and state=IDLE. Key held through release -> DEBOUNCE restarts and keyEvent occurs 3 frames later.
REQ-035 startOfFrame coincident with the DEBOUNCE release cycle -> IDLE, counter=0, no keyEvent.
